// File: rtl/csa_accumulator.sv
// ---------------------------------------------------------------------------
// csa_accumulator
//
// Multi-operand accumulator that keeps its running total in redundant
// carry-save form (sum vector S plus carry vector C). Each accepted operand
// costs one 3:2 compression step, so the per-beat path is a single full-adder
// level regardless of width. When the last operand of a group has been
// absorbed, S and C are resolved once by a carry-propagate add and the W-bit
// result is offered on the output port.
//
// Parameters
//   N      operand width
//   G      guard bits; result width W = N + G; beat counter width G
//   SIGNED 1 = operands sign-extended to W, 0 = zero-extended
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   block can accept a beat (registered)
//   in_data    operand, N bits
//   in_last    marks the final operand of the current group
//   out_valid  resolved result available (registered)
//   out_ready  consumer accepts the result
//   out_sum    resolved group sum, modulo 2^W
//   out_count  beats in the group, saturating at 2^G-1
//   out_ovf    group had more than 2^G-1 beats; out_sum may have wrapped
//   dbg_state  current FSM state (ACCUM=0, RESOLVE=1, DONE=2)
//
// Handshake rule for both ports: a transfer happens on a rising clk edge
// where valid and ready are both high. While valid is high and ready is low
// the source holds its data stable. Neither valid nor ready is derived
// combinationally from the other side's signals (both are flops here).
// ---------------------------------------------------------------------------
module csa_accumulator #(
  parameter int N      = 32,
  parameter int G      = 8,
  parameter bit SIGNED = 1'b0,
  localparam int W     = N + G
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic [G-1:0] out_count,
  output logic         out_ovf,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t       state;

  // Redundant accumulator. c_q always holds the carry vector already shifted
  // into its final bit positions, so S + C is the true running total.
  logic [W-1:0] s_q;
  logic [W-1:0] c_q;
  logic [G-1:0] count_q;
  logic         ovf_q;

  // ---------------------------------------------------------------------
  // Combinational datapath
  // ---------------------------------------------------------------------
  logic [W-1:0] x_ext;     // operand widened to W bits
  logic [W-1:0] s_nxt;     // 3:2 compressor sum output
  logic [W-1:0] c_nxt;     // 3:2 compressor carry output, pre-shifted
  logic [W-1:0] resolved;  // carry-propagate resolution of S + C
  logic         beat;      // operand transfer this cycle
  logic         out_fire;  // result transfer this cycle
  logic         count_max; // beat counter is saturated

  always_comb begin
    x_ext = SIGNED ? {{G{in_data[N-1]}}, in_data} : {{G{1'b0}}, in_data};
  end

  // One full-adder level per bit. The carry out of the top bit is dropped by
  // the W-bit shift, which is exactly the mod 2^W behaviour of the result.
  always_comb begin
    s_nxt = s_q ^ c_q ^ x_ext;
    c_nxt = ((s_q & c_q) | (s_q & x_ext) | (c_q & x_ext)) << 1;
  end

  always_comb begin
    resolved = s_q + c_q;
  end

  always_comb begin
    beat      = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
    count_max = &count_q;
  end

  assign dbg_state = state;

  // ---------------------------------------------------------------------
  // Control FSM and all state registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      s_q       <= '0;
      c_q       <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (beat) begin
            s_q <= s_nxt;
            c_q <= c_nxt;
            // The counter stops at all-ones; a beat arriving while it is
            // already saturated is what flags the group as overflowed.
            if (count_max) begin
              ovf_q <= 1'b1;
            end else begin
              count_q <= count_q + {{(G-1){1'b0}}, 1'b1};
            end
            if (in_last) begin
              state    <= RESOLVE;
              in_ready <= 1'b0;
            end
          end
        end

        RESOLVE: begin
          // The only carry-propagate add in the block happens here, once per
          // group. count_q/ovf_q are stable because no beat can be taken.
          out_sum   <= resolved;
          out_count <= count_q;
          out_ovf   <= ovf_q;
          state     <= DONE;
        end

        DONE: begin
          // out_valid rises one cycle after entering DONE, so the result
          // registers have a full cycle to settle before being advertised.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_fire) begin
            // Clearing here makes the next group start from zero without
            // touching the result registers the consumer just sampled.
            s_q       <= '0;
            c_q       <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ACCUM;
          end
        end

        default: begin
          state    <= ACCUM;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accumulator.sv
// ---------------------------------------------------------------------------
// tb_csa_accumulator
//
// Two instances of csa_accumulator (SIGNED=0 and SIGNED=1) share one stimulus
// stream and run in lockstep. Each group's expected results for both
// instances are pushed to exp_q when its last beat is accepted and popped by
// the output monitor at the result handshake. After every accepted beat the
// redundant S + C of each instance is asserted against a running sum kept by
// the bench.
// ---------------------------------------------------------------------------
module tb_csa_accumulator;

  localparam int N = 32;
  localparam int G = 8;
  localparam int W = N + G;

  // ---------------------------------------------------------------------
  // Clock / reset and DUT wiring
  // ---------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [N-1:0] in_data;
  logic         in_last;
  logic         out_ready;

  logic         in_ready_u, in_ready_s;
  logic         out_valid_u, out_valid_s;
  logic [W-1:0] out_sum_u, out_sum_s;
  logic [G-1:0] out_count_u, out_count_s;
  logic         out_ovf_u, out_ovf_s;
  logic [1:0]   dbg_state_u, dbg_state_s;

  always #5 clk = ~clk;

  csa_accumulator #(.N(N), .G(G), .SIGNED(1'b0)) dut_u (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_u),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid_u),
    .out_ready (out_ready),
    .out_sum   (out_sum_u),
    .out_count (out_count_u),
    .out_ovf   (out_ovf_u),
    .dbg_state (dbg_state_u)
  );

  csa_accumulator #(.N(N), .G(G), .SIGNED(1'b1)) dut_s (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_s),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid_s),
    .out_ready (out_ready),
    .out_sum   (out_sum_s),
    .out_count (out_count_s),
    .out_ovf   (out_ovf_s),
    .dbg_state (dbg_state_s)
  );

  // ---------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------
  typedef struct packed {
    logic [W-1:0] sum_u;
    logic [W-1:0] sum_s;
    logic [G-1:0] cnt;
    logic         ovf;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Running model of the group in progress.
  logic [W-1:0] run_u;
  logic [W-1:0] run_s;
  logic [G-1:0] run_n;
  logic         run_ovf;

  // Table of directed groups with hand-computed results.
  typedef struct {
    int               nbeats;
    logic [3:0][N-1:0] d;
    logic [W-1:0]     sum_u;
    logic [W-1:0]     sum_s;
    logic [G-1:0]     cnt;
  } vec_t;

  vec_t tbl[6];

  function automatic vec_t mk(input int n, input logic [N-1:0] a, input logic [N-1:0] b,
                              input logic [N-1:0] c, input logic [N-1:0] e,
                              input logic [W-1:0] su, input logic [W-1:0] ss);
    vec_t v;
    v.nbeats = n;
    v.d[0]   = a;
    v.d[1]   = b;
    v.d[2]   = c;
    v.d[3]   = e;
    v.sum_u  = su;
    v.sum_s  = ss;
    v.cnt    = G'(n);
    return v;
  endfunction

  // ---------------------------------------------------------------------
  // Check helpers
  // ---------------------------------------------------------------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_invariant();
    logic [W-1:0] sc_u;
    logic [W-1:0] sc_s;
    sc_u = dut_u.s_q + dut_u.c_q;
    sc_s = dut_s.s_q + dut_s.c_q;
    checks++;
    assert (sc_u == run_u) else begin
      errors++;
      $display("FAIL invariant_u: S+C=%h expected %h", sc_u, run_u);
    end
    checks++;
    assert (sc_s == run_s) else begin
      errors++;
      $display("FAIL invariant_s: S+C=%h expected %h", sc_s, run_s);
    end
  endtask

  task automatic clear_model();
    run_u   = '0;
    run_s   = '0;
    run_n   = '0;
    run_ovf = 1'b0;
  endtask

  task automatic push_exp(input logic [W-1:0] su, input logic [W-1:0] ss,
                          input logic [G-1:0] c, input logic o);
    exp_t e;
    e.sum_u = su;
    e.sum_s = ss;
    e.cnt   = c;
    e.ovf   = o;
    exp_q.push_back(e);
    clear_model();
  endtask

  // ---------------------------------------------------------------------
  // Driver tasks (all input changes happen at negedge)
  // ---------------------------------------------------------------------
  task automatic do_reset(input int cycles);
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    clear_model();
  endtask

  // Present one beat, wait (bounded) for acceptance, update the model and
  // check the carry-save invariant. Leaves in_valid high for non-last beats
  // so consecutive calls stream back-to-back.
  task automatic send_beat(input logic [N-1:0] d, input logic last);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready_u && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready_u) begin
      checks++;
      errors++;
      $display("FAIL beat_accept_timeout: in_ready=%b expected 1", in_ready_u);
      in_valid = 1'b0;
      in_last  = 1'b0;
      return;
    end
    @(negedge clk);
    run_u = run_u + {{G{1'b0}}, d};
    run_s = run_s + {{G{d[N-1]}}, d};
    if (run_n == {G{1'b1}}) run_ovf = 1'b1;
    else run_n = run_n + 1'b1;
    chk_invariant();
    if (last) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic wait_valid(input string name);
    int g;
    g = 0;
    while (!out_valid_u && g < 20) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (!out_valid_u) begin
      errors++;
      $display("FAIL %s: out_valid=%b expected 1 within 20 cycles", name, out_valid_u);
    end
  endtask

  // ---------------------------------------------------------------------
  // Output monitor: compares at every result handshake
  // ---------------------------------------------------------------------
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (!rst && out_valid_u && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: sum=%h with no result pending", out_sum_u);
      end else begin
        e = exp_q.pop_front();
        chk("out_sum_u",   out_sum_u,   e.sum_u);
        chk("out_count_u", W'(out_count_u), W'(e.cnt));
        chk("out_ovf_u",   W'(out_ovf_u),   W'(e.ovf));
        chk("out_valid_s", W'(out_valid_s), W'(1'b1));
        chk("out_sum_s",   out_sum_s,   e.sum_s);
        chk("out_count_s", W'(out_count_s), W'(e.cnt));
        chk("out_ovf_s",   W'(out_ovf_s),   W'(e.ovf));
      end
    end
  end

  // Hang guard.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------
  initial begin
    int n;
    int gap;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    clear_model();

    tbl[0] = mk(3, 32'd5, 32'd7, 32'd9, 32'd0, 40'd21, 40'd21);
    tbl[1] = mk(4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                40'h03_FFFF_FFFC, 40'hFF_FFFF_FFFC);
    tbl[2] = mk(3, 32'hFFFF_FFFE, 32'h1, 32'h8000_0000, 32'h0,
                40'h01_7FFF_FFFF, 40'hFF_7FFF_FFFF);
    tbl[3] = mk(1, 32'h1234, 32'h0, 32'h0, 32'h0, 40'h1234, 40'h1234);
    tbl[4] = mk(4, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000,
                40'h01_FFFF_FFFE, 40'hFF_FFFF_FFFE);
    tbl[5] = mk(2, 32'h0, 32'h0, 32'h0, 32'h0, 40'h0, 40'h0);

    @(negedge clk);
    do_reset(3);

    // Reset state.
    chk("rst_out_valid", W'(out_valid_u), W'(1'b0));
    chk("rst_in_ready",  W'(in_ready_u),  W'(1'b1));
    chk("rst_out_sum",   out_sum_u,       W'(0));
    chk("rst_out_count", W'(out_count_u), W'(0));
    chk("rst_out_ovf",   W'(out_ovf_u),   W'(0));
    chk("rst_state",     W'(dbg_state_u), W'(0));
    chk("rst_in_ready_s", W'(in_ready_s), W'(1'b1));

    // Latency and in_ready during resolution: 5, 7, 9(last).
    send_beat(32'd5, 1'b0);
    send_beat(32'd7, 1'b0);
    send_beat(32'd9, 1'b1);
    push_exp(40'd21, 40'd21, 8'd3, 1'b0);
    chk("lat_valid_t0", W'(out_valid_u), W'(1'b0));
    chk("lat_ready_t0", W'(in_ready_u),  W'(1'b0));
    chk("lat_state_t0", W'(dbg_state_u), W'(1));
    @(negedge clk);
    chk("lat_valid_t1", W'(out_valid_u), W'(1'b0));
    @(negedge clk);
    chk("lat_valid_t2", W'(out_valid_u), W'(1'b1));

    // Table-driven groups, back-to-back beats.
    for (int v = 0; v < 6; v++) begin
      for (int b = 0; b < tbl[v].nbeats; b++) begin
        send_beat(tbl[v].d[b], b == tbl[v].nbeats - 1);
      end
      push_exp(tbl[v].sum_u, tbl[v].sum_s, tbl[v].cnt, 1'b0);
    end

    // Output backpressure: held result, stalled input, restart from zero.
    wait_valid("pre_stall_drain");
    @(negedge clk);
    out_ready = 1'b0;
    send_beat(32'h1234, 1'b1);
    push_exp(40'h1234, 40'h1234, 8'd1, 1'b0);
    wait_valid("stall_valid");
    in_valid = 1'b1;
    in_data  = 32'hBEEF;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_out_valid", W'(out_valid_u), W'(1'b1));
      chk("stall_out_sum",   out_sum_u,       40'h1234);
      chk("stall_out_count", W'(out_count_u), W'(1));
      chk("stall_in_ready",  W'(in_ready_u),  W'(1'b0));
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_hs_out_valid", W'(out_valid_u), W'(1'b0));
    chk("post_hs_in_ready",  W'(in_ready_u),  W'(1'b1));
    send_beat(32'h10, 1'b1);
    push_exp(40'h10, 40'h10, 8'd1, 1'b0);

    // Beat-count saturation: 256 beats of 1.
    for (int i = 0; i < 256; i++) begin
      send_beat(32'd1, i == 255);
    end
    push_exp(40'd256, 40'd256, 8'd255, 1'b1);

    // Reset during the 3rd beat of a group.
    wait_valid("pre_reset_drain");
    @(negedge clk);
    send_beat(32'd10, 1'b0);
    send_beat(32'd20, 1'b0);
    in_data  = 32'd30;
    in_valid = 1'b1;
    rst      = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    clear_model();
    chk("midrst_out_valid", W'(out_valid_u), W'(1'b0));
    chk("midrst_in_ready",  W'(in_ready_u),  W'(1'b1));
    chk("midrst_state",     W'(dbg_state_u), W'(0));
    send_beat(32'd2, 1'b0);
    send_beat(32'd3, 1'b1);
    push_exp(40'd5, 40'd5, 8'd2, 1'b0);

    // Reset while a result is pending: it must never be emitted.
    wait_valid("pre_done_reset_drain");
    @(negedge clk);
    out_ready = 1'b0;
    send_beat(32'h77, 1'b1);
    push_exp(40'h77, 40'h77, 8'd1, 1'b0);
    wait_valid("done_reset_valid");
    rst = 1'b1;
    exp_q.delete();
    clear_model();
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    chk("donerst_out_valid", W'(out_valid_u), W'(1'b0));
    chk("donerst_out_sum",   out_sum_u,       W'(0));
    chk("donerst_in_ready",  W'(in_ready_u),  W'(1'b1));

    // Random groups with idle gaps; in_last without in_valid is ignored.
    for (int grp = 0; grp < 8; grp++) begin
      n = $urandom_range(1, 6);
      for (int b = 0; b < n; b++) begin
        gap = $urandom_range(0, 2);
        for (int k = 0; k < gap; k++) begin
          in_valid = 1'b0;
          in_data  = $urandom;
          in_last  = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
        send_beat($urandom, b == n - 1);
      end
      push_exp(run_u, run_s, run_n, run_ovf);
    end

    // Drain the scoreboard.
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
